// File: rtl/plb_dac_pkg.sv
// Shared definitions for the PLB DAC sample engine: source modes, FSM states,
// LFSR constants and the midscale helper.
package plb_dac_pkg;

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_FIFO = 2'd1;
  localparam logic [1:0] MODE_PN   = 2'd2;
  localparam logic [1:0] MODE_RAMP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } dac_state_e;

  // x^15 + x^14 + 1: feedback is the XOR of bits 14 and 13.
  localparam logic [14:0] LFSR_SEED = 15'h7FFF;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

  function automatic logic [15:0] midscale(input int width);
    return 16'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO with occupancy level. Pushes when full and pops
// when empty are ignored; a pop while empty never bypasses a same-cycle push.
module dac_sample_fifo #(
  parameter int C_DATA_W     = 10,
  parameter int C_FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_DATA_W-1:0]             wr_data,
  input  logic                            push,
  input  logic                            pop,
  output logic [C_DATA_W-1:0]             rd_data,
  output logic [$clog2(C_FIFO_DEPTH):0]   level,
  output logic                            full,
  output logic                            empty
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [C_DATA_W-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (level == LW'(C_FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/plb_dac_stream.sv
// DAC sample engine: IDLE/PRIME/RUN sequencer, sample-rate divider, FIFO/PN/
// ramp/hold sources and offset-binary / two's-complement output formatting.
module plb_dac_stream
  import plb_dac_pkg::*;
#(
  parameter int C_DATA_W     = 10,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_DIV_W      = 8,
  parameter int C_PRIME      = 8
) (
  input  logic                          Bus2IP_Clk,
  input  logic                          Bus2IP_Reset,
  input  logic                          cfg_enable,
  input  logic [1:0]                    cfg_mode,
  input  logic [C_DIV_W-1:0]            cfg_div,
  input  logic                          cfg_twos,
  input  logic [C_DATA_W-1:0]           wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(C_FIFO_DEPTH):0] fifo_level,
  input  logic                          clr_status,
  output logic                          underrun,
  output logic [C_DATA_W-1:0]           dac_data,
  output logic                          dac_clk,
  output logic                          dac_pwrdn
);

  localparam int LW = $clog2(C_FIFO_DEPTH) + 1;
  localparam logic [C_DATA_W-1:0] MID = C_DATA_W'(midscale(C_DATA_W));

  dac_state_e state, state_next;

  logic [1:0]          mode_q, mode_act;
  logic [C_DIV_W-1:0]  div_q, div_act;
  logic                twos_q, twos_act;
  logic [C_DIV_W-1:0]  phase, phase_last;
  logic [C_DIV_W:0]    period, half;
  logic [14:0]         lfsr;
  logic [C_DATA_W-1:0] ramp;
  logic [C_DATA_W-1:0] src_val;
  logic                src_upd;
  logic                tick, enter, stay_run;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [C_DATA_W-1:0] fifo_rd;

  dac_sample_fifo #(
    .C_DATA_W     (C_DATA_W),
    .C_FIFO_DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (Bus2IP_Clk),
    .rst     (Bus2IP_Reset),
    .wr_data (wr_data),
    .push    (wr_valid),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign wr_ready  = !fifo_full;
  assign dac_pwrdn = (state == ST_IDLE);

  // Configuration is transparent in IDLE and frozen once the engine starts.
  assign mode_act = (state == ST_IDLE) ? cfg_mode : mode_q;
  assign div_act  = (state == ST_IDLE) ? cfg_div  : div_q;
  assign twos_act = (state == ST_IDLE) ? cfg_twos : twos_q;

  assign phase_last = (div_act == '0) ? C_DIV_W'(1) : div_act;
  assign period     = {1'b0, phase_last} + 1'b1;
  assign half       = period >> 1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (cfg_enable) state_next = (mode_act == MODE_FIFO) ? ST_PRIME : ST_RUN;
      ST_PRIME: if (fifo_level >= LW'(C_PRIME)) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
    if (!cfg_enable) state_next = ST_IDLE;
  end

  assign stay_run = (state == ST_RUN) && (state_next == ST_RUN);
  assign tick     = stay_run && (phase == '0);
  assign enter    = (state == ST_IDLE) && (state_next != ST_IDLE);
  assign fifo_pop = tick && (mode_q == MODE_FIFO) && !fifo_empty;

  always_comb begin
    src_val = MID;
    src_upd = tick;
    case (mode_q)
      MODE_FIFO: begin
        src_val = fifo_rd;
        src_upd = tick && !fifo_empty;
      end
      MODE_PN:   src_val = lfsr[C_DATA_W-1:0];
      MODE_RAMP: src_val = ramp;
      default:   src_val = MID;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state  <= ST_IDLE;
      mode_q <= MODE_HOLD;
      div_q  <= '0;
      twos_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE) begin
        mode_q <= cfg_mode;
        div_q  <= cfg_div;
        twos_q <= cfg_twos;
      end
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      phase    <= '0;
      lfsr     <= LFSR_SEED;
      ramp     <= '0;
      underrun <= 1'b0;
    end else begin
      phase <= (stay_run && phase != phase_last) ? phase + 1'b1 : '0;

      if (enter)
        lfsr <= LFSR_SEED;
      else if (tick && mode_q == MODE_PN)
        lfsr <= {lfsr[13:0], ^(lfsr & LFSR_TAPS)};

      if (enter)
        ramp <= '0;
      else if (tick && mode_q == MODE_RAMP)
        ramp <= ramp + 1'b1;

      // A new underrun wins over a same-cycle clear.
      if (tick && mode_q == MODE_FIFO && fifo_empty)
        underrun <= 1'b1;
      else if (clr_status)
        underrun <= 1'b0;
    end
  end

  // Output stage is one cycle behind the phase counter, so new data and the
  // falling dac_clk edge appear together.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      dac_data <= MID;
      dac_clk  <= 1'b0;
    end else begin
      if (src_upd)
        dac_data <= src_val ^ {twos_q, {(C_DATA_W-1){1'b0}}};
      else if (!stay_run)
        dac_data <= MID ^ {twos_act, {(C_DATA_W-1){1'b0}}};
      dac_clk <= stay_run && ({1'b0, phase} >= half);
    end
  end

endmodule
